// File: rtl/gate_checker_if.sv
// Bundle of handshake, stimulus and result signals between a gate checker
// and the logic that drives it. The master starts/aborts runs and supplies
// the gate outputs; the slave (the checker) drives the gate inputs and results.
interface gate_checker_if;
  logic       start;
  logic       abort;
  logic [6:0] dut_out;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic [6:0] diff_mask;

  modport master (
    output start,
    output abort,
    output dut_out,
    input  a_out,
    input  b_out,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_mask,
    input  diff_mask
  );

  modport slave (
    input  start,
    input  abort,
    input  dut_out,
    output a_out,
    output b_out,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_mask,
    output diff_mask
  );
endinterface

// File: rtl/gate_checker.sv
// Exhaustive two-input gate checker. Walks {a,b} through 00,01,10,11, holds
// each vector for SETTLE_CYCLES cycles, then compares the seven gate outputs
// against their ideal values and accumulates per-vector and per-output errors.
module gate_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic          clk,
  input logic          rst_n,
  gate_checker_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  // Last settle count before moving on to SAMPLE.
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic [6:0] diff_q, diff_d;

  logic       va;
  logic       vb;
  logic [6:0] expected;
  logic [6:0] mismatch;

  // Ideal gate outputs for the current vector and their difference from the gate.
  always_comb begin
    va       = vec_q[1];
    vb       = vec_q[0];
    expected = {va & vb, va | vb, ~va, ~(va & vb), ~(va | vb), va ^ vb, ~(va ^ vb)};
    mismatch = bus.dut_out ^ expected;
  end

  // Next-state, result accumulation and registered output decode.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    diff_d  = diff_q;

    unique case (state_q)
      StIdle: begin
        // Abort is meaningless here; start alone decides.
        if (bus.start) begin
          state_d = StSettle;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          diff_d  = 7'd0;
        end
      end

      StSettle: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (cnt_q == SettleLast) begin
          state_d = StSample;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      StSample: begin
        // Abort wins over a same-cycle mismatch: results keep partial values.
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          if (|mismatch) begin
            err_d         = (err_q == 3'd4) ? 3'd4 : err_q + 3'd1;
            fail_d[vec_q] = 1'b1;
            diff_d        = diff_q | mismatch;
          end
          if (vec_q == 2'd3) begin
            state_d = StDone;
            pass_d  = (err_d == 3'd0);
          end else begin
            state_d = StSettle;
            vec_d   = vec_q + 2'd1;
            cnt_d   = 4'd0;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered so they follow the state register exactly.
    busy_d = (state_d == StSettle) || (state_d == StSample);
    done_d = (state_d == StDone);
    a_d    = busy_d & vec_d[1];
    b_d    = busy_d & vec_d[0];
  end

  // State, counters, results and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
      diff_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      diff_q  <= diff_d;
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = fail_q;
  assign bus.diff_mask = diff_q;

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameters SHALL be:
- SETTLE_CYCLES, default 2, cycles that a vector is held before its outputs are sampled; legal range 1..15.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a check run; sampled only in IDLE.
- abort  in  1  cancel a run in progress.
- dut_out  in  7  gate outputs under test: [6] and, [5] or, [4] not(a), [3] nand, [2] nor, [1] xor, [0] xnor.
- a_out  out  1  registered drive to gate input a.
- b_out  out  1  registered drive to gate input b.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  last completed run had zero mismatches.
- err_count  out  3  number of mismatching vectors in the current or last run, 0..4.
- fail_mask  out  4  bit v set when vector v ({a,b}=v) mismatched.
- diff_mask  out  7  OR over all sampled vectors of (dut_out XOR expected).

Function
REQ-004 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and DONE, with a 2-bit vector index vec and a 4-bit settle counter.
REQ-005 In IDLE with start=1, the FSM SHALL take the following actions at the next edge:
- go to SETTLE with vec=0 and the counter at 0;
- set busy=1;
- clear err_count, fail_mask, diff_mask and pass.
REQ-006 {a_out,b_out} SHALL equal vec while in SETTLE and SAMPLE, and SHALL be 0 in IDLE and DONE.
REQ-007 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then the FSM SHALL go to SAMPLE.
REQ-008 SAMPLE SHALL last one cycle, and in it expected = {a&b, a|b, ~a, ~(a&b), ~(a|b), a^b, ~(a^b)} for a=vec[1], b=vec[0].
REQ-009 On mismatch in SAMPLE, the block SHALL do all of the following at the same edge:
- increment err_count by 1;
- set fail_mask[vec];
- OR the mismatch bits into diff_mask.
REQ-010 From SAMPLE, the FSM SHALL:
- when vec<3, increment vec and go to SETTLE with the counter at 0;
- when vec=3, go to DONE.
REQ-011 Vector order SHALL be 00, 01, 10, 11, with no wrap or repeat within a run.
REQ-012 DONE SHALL last one cycle, assert done=1 and busy=0, and load pass=(err_count==0) after the last sample update; the FSM then SHALL return to IDLE unconditionally.
REQ-013 Latency: if start is accepted at edge 0, done SHALL be high after edge 4*(SETTLE_CYCLES+1); for default 2, that is edge 12.
REQ-014 start SHALL be ignored in SETTLE, SAMPLE and DONE, and a new run SHALL begin only from IDLE.
REQ-015 abort=1 in SETTLE or SAMPLE SHALL cause the FSM to:
- go to IDLE at the next edge with busy=0 and done not pulsed;
- leave pass at 0;
- hold err_count, fail_mask and diff_mask at their partial values.
REQ-016 If abort and a SAMPLE mismatch occur in the same cycle, abort SHALL win and the counters and masks SHALL NOT update.
REQ-017 abort SHALL have no effect in IDLE or DONE.
REQ-018 If start and abort are both 1 in IDLE, start SHALL win.
REQ-019 pass, err_count, fail_mask and diff_mask SHALL hold their values until the next accepted start or reset.
REQ-020 err_count SHALL never exceed 4 and SHALL NOT wrap.
REQ-021 dut_out SHALL be sampled only in SAMPLE, and its value in all other states SHALL be ignored.

Reset
REQ-022 rst_n=0 SHALL immediately force:
- state=IDLE, vec=0, settle counter=0;
- a_out=0, b_out=0, busy=0, done=0, pass=0;
- err_count=0, fail_mask=0, diff_mask=0.
REQ-023 Reset asserted mid-run SHALL discard the run, and done SHALL NOT pulse.
REQ-024 After rst_n rises, the first start SHALL be accepted at the first rising edge at which it is sampled high.

Verification
REQ-025 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Correct gate model: start -> vectors 00,01,10,11 appear with 3 cycles per vector; done at edge 12; pass=1, err_count=0, fail_mask=0000, diff_mask=0.
- xor output stuck at 0: err_count=2, fail_mask=0110, diff_mask=0000010, pass=0.
- All seven outputs inverted: err_count=4, fail_mask=1111, diff_mask=1111111, pass=0.
- start pulsed again at edge 5 of a run: ignored, done still at edge 12 only; a second start after done begins a fresh run with cleared results.
- abort at vec=2 in SAMPLE, with xor stuck at 0: IDLE next edge, no done, pass=0, err_count=1, fail_mask=0010.
- rst_n low at edge 7, then a correct-model run: all outputs 0 immediately; the following run completes normally with pass=1.
